// File: rtl/mask_expand_unit_pkg.sv
// Shared types for the vector expand unit.
// Lane count, FSM state encoding, lane mask type.
package vexp_pkg;

  localparam int LANES = 16;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    EMIT
  } state_e;

  typedef logic [LANES-1:0] lane_mask_t;

endpackage

// File: rtl/mask_expand_unit_if.sv
// Mask, packed-source and expanded-group handshake bundle.
// master = producer/consumer side, slave = expand unit.
interface mask_expand_unit_if #(
  parameter int ELEM_W = 32
);
  import vexp_pkg::*;

  logic                    mask_valid_i;
  logic                    mask_ready_o;
  lane_mask_t              mask_i;
  logic                    mask_last_i;
  logic                    src_valid_i;
  logic                    src_ready_o;
  logic [ELEM_W-1:0]       src_data_i;
  logic                    out_valid_o;
  logic                    out_ready_i;
  logic [LANES*ELEM_W-1:0] out_data_o;
  lane_mask_t              out_lane_en_o;
  logic                    out_last_o;

  modport master (
    output mask_valid_i,
    input  mask_ready_o,
    output mask_i,
    output mask_last_i,
    output src_valid_i,
    input  src_ready_o,
    output src_data_i,
    input  out_valid_o,
    output out_ready_i,
    input  out_data_o,
    input  out_lane_en_o,
    input  out_last_o
  );

  modport slave (
    input  mask_valid_i,
    output mask_ready_o,
    input  mask_i,
    input  mask_last_i,
    input  src_valid_i,
    output src_ready_o,
    input  src_data_i,
    output out_valid_o,
    input  out_ready_i,
    output out_data_o,
    output out_lane_en_o,
    output out_last_o
  );

endinterface

// File: rtl/find_next_set16.sv
// Lowest-set-bit picker: vec -> one-hot of lowest set bit.
// Ports: vec in, onehot out, any out (vec != 0).
module find_next_set16
  import vexp_pkg::*;
(
  input  lane_mask_t vec,
  output lane_mask_t onehot,
  output logic       any
);

  // Two's-complement trick isolates the lowest set bit.
  assign onehot = vec & (~vec + 16'd1);
  assign any    = |vec;

endmodule

// File: rtl/mask_expand_unit.sv
// Streaming expand: scatters packed elements into set-mask lanes.
// Ports: clk, rst_n (sync, active-low), bus (slave), src_cnt_o,
// busy_o. Macro VEXP_ZERO_FILL_EN zeroes inactive lanes.
module mask_expand_unit #(
  parameter int ELEM_W = 32,
  parameter int LANES  = 16,
  parameter int CNT_W  = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mask_expand_unit_if.slave    bus,
  output logic [CNT_W-1:0]     src_cnt_o,
  output logic                 busy_o
);
  import vexp_pkg::*;

  if (LANES != 16) begin : g_lanes_chk
    $error("mask_expand_unit: LANES must be 16");
  end

  state_e                  state;
  lane_mask_t              pend;
  lane_mask_t              filled;
  lane_mask_t              open;
  lane_mask_t              nxt;
  logic                    any;
  logic                    last_q;
  logic [16*ELEM_W-1:0]    data_q;
  logic [CNT_W-1:0]        cnt;
  logic                    mask_hs;
  logic                    src_hs;
  logic                    out_hs;
  logic                    fin;

  assign open = pend & ~filled;

  find_next_set16 u_fns (
    .vec    (open),
    .onehot (nxt),
    .any    (any)
  );

  assign mask_hs = bus.mask_valid_i && state == IDLE;
  assign src_hs  = bus.src_valid_i && state == FILL;
  assign out_hs  = bus.out_ready_i && state == EMIT;
  // Chunk complete once the picked bit was the only open one.
  assign fin     = (open & ~nxt) == '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      pend   <= '0;
      filled <= '0;
      last_q <= 1'b0;
      data_q <= '0;
      cnt    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (mask_hs) begin
            pend   <= bus.mask_i;
            last_q <= bus.mask_last_i;
            filled <= '0;
            state  <= (bus.mask_i == '0) ? EMIT : FILL;
          end
        end
        FILL: begin
          if (src_hs && any) begin
            for (int i = 0; i < 16; i++) begin
              if (nxt[i]) begin
                data_q[i*ELEM_W +: ELEM_W] <= bus.src_data_i;
              end
            end
            filled <= filled | nxt;
            cnt    <= cnt + 1'b1;
            if (fin) state <= EMIT;
          end
        end
        EMIT: begin
          if (out_hs) begin
            state <= IDLE;
            if (last_q) cnt <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.mask_ready_o  = state == IDLE;
  assign bus.src_ready_o   = state == FILL;
  assign bus.out_valid_o   = state == EMIT;
  assign bus.out_lane_en_o = pend;
  assign bus.out_last_o    = last_q;
  assign src_cnt_o         = cnt;
  assign busy_o            = state != IDLE;

  for (genvar g = 0; g < 16; g++) begin : g_lane
`ifdef VEXP_ZERO_FILL_EN
    assign bus.out_data_o[g*ELEM_W +: ELEM_W] =
      pend[g] ? data_q[g*ELEM_W +: ELEM_W] : '0;
`else
    assign bus.out_data_o[g*ELEM_W +: ELEM_W] =
      data_q[g*ELEM_W +: ELEM_W];
`endif
  end

endmodule

// File: tb/tb_mask_expand_unit.sv
// Self-checking bench for mask_expand_unit.
// Table-driven chunks with a scoreboard of expected groups.
module tb_mask_expand_unit;
  import vexp_pkg::*;

  localparam int W  = 32;
  localparam int CW = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mask_expand_unit_if #(.ELEM_W(W)) bus ();
  logic [CW-1:0] src_cnt;
  logic          busy;

  mask_expand_unit #(
    .ELEM_W (W),
    .LANES  (16),
    .CNT_W  (CW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus.slave),
    .src_cnt_o (src_cnt),
    .busy_o    (busy)
  );

  typedef struct {
    logic [15:0] mask;
    logic        last;
    logic [31:0] base;
    int          hold;
  } vec_t;

  typedef struct {
    logic [16*W-1:0] data;
    logic [15:0]     en;
    logic            last;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mdl[16];
  int          mcnt;
  int          pass;
  int          total;
  vec_t        tbl[8];

  task automatic chk(input string name,
                     input logic [16*W-1:0] act,
                     input logic [16*W-1:0] exp);
    total++;
    if (act === exp) pass++;
    else $display("FAIL %s: got %0h want %0h", name, act, exp);
  endtask

  task automatic run_chunk(input logic [15:0] mask,
                           input logic last,
                           input logic [31:0] base,
                           input int hold);
    exp_t e;
    int   k;
    k = 0;
    @(negedge clk);
    chk("mask_ready", bus.mask_ready_o, 1);
    bus.mask_valid_i = 1'b1;
    bus.mask_i       = mask;
    bus.mask_last_i  = last;
    for (int i = 0; i < 16; i++) begin
      if (mask[i]) begin
        mdl[i] = base + k;
        k++;
      end
    end
    e.data = '0;
    for (int i = 0; i < 16; i++) begin
`ifdef VEXP_ZERO_FILL_EN
      e.data[i*W +: W] = mask[i] ? mdl[i] : 32'd0;
`else
      e.data[i*W +: W] = mdl[i];
`endif
    end
    e.en   = mask;
    e.last = last;
    sb.push_back(e);
    @(negedge clk);
    bus.mask_valid_i = 1'b0;
    for (int j = 0; j < k; j++) begin
      chk("src_ready", bus.src_ready_o, 1);
      chk("no_out_early", bus.out_valid_o, 0);
      bus.src_valid_i = 1'b1;
      bus.src_data_i  = base + j;
      @(negedge clk);
    end
    bus.src_valid_i = 1'b0;
    mcnt += k;
    chk("out_valid_latency", bus.out_valid_o, 1);
    chk("src_cnt_emit", src_cnt, mcnt);
    if (sb.size() == 0) begin
      total++;
      $display("FAIL sb_empty: got 0 entries want 1");
    end else begin
      e = sb.pop_front();
      for (int h = 0; h < hold; h++) begin
        bus.src_valid_i  = 1'b1;
        bus.mask_valid_i = 1'b1;
        @(negedge clk);
        chk("hold_valid", bus.out_valid_o, 1);
        chk("hold_data", bus.out_data_o, e.data);
        chk("hold_mask_rdy", bus.mask_ready_o, 0);
        chk("hold_src_rdy", bus.src_ready_o, 0);
        chk("hold_cnt", src_cnt, mcnt);
      end
      bus.src_valid_i  = 1'b0;
      bus.mask_valid_i = 1'b0;
      chk("out_data", bus.out_data_o, e.data);
      chk("lane_en", bus.out_lane_en_o, e.en);
      chk("out_last", bus.out_last_o, e.last);
    end
    bus.out_ready_i = 1'b1;
    @(negedge clk);
    bus.out_ready_i = 1'b0;
    if (last) mcnt = 0;
    chk("idle_after", busy, 0);
    chk("out_valid_drop", bus.out_valid_o, 0);
    chk("src_cnt_after", src_cnt, mcnt);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    pass = 0;
    total = 0;
    mcnt = 0;
    for (int i = 0; i < 16; i++) mdl[i] = '0;
    tbl[0] = '{16'h0000, 1'b1, 32'h0,   0};
    tbl[1] = '{16'h8421, 1'b1, 32'hA,   0};
    tbl[2] = '{16'hFFFF, 1'b1, 32'h40,  5};
    tbl[3] = '{16'h0003, 1'b0, 32'h1,   0};
    tbl[4] = '{16'h0100, 1'b1, 32'h3,   1};
    tbl[5] = '{16'h5A5A, 1'b0, 32'h100, 2};
    tbl[6] = '{16'h0000, 1'b0, 32'h0,   0};
    tbl[7] = '{16'h0001, 1'b1, 32'h200, 0};

    rst_n            = 1'b0;
    bus.mask_valid_i = 1'b0;
    bus.mask_i       = '0;
    bus.mask_last_i  = 1'b0;
    bus.src_valid_i  = 1'b0;
    bus.src_data_i   = '0;
    bus.out_ready_i  = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_mask_ready", bus.mask_ready_o, 1);
    chk("rst_src_ready", bus.src_ready_o, 0);
    chk("rst_out_valid", bus.out_valid_o, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cnt", src_cnt, 0);
    chk("rst_lane_en", bus.out_lane_en_o, 0);
    chk("rst_last", bus.out_last_o, 0);
    chk("rst_data", bus.out_data_o, 0);

    for (int t = 0; t < 8; t++) begin
      run_chunk(tbl[t].mask, tbl[t].last,
                tbl[t].base, tbl[t].hold);
    end

    // src beats in IDLE must be ignored
    bus.src_valid_i = 1'b1;
    bus.src_data_i  = 32'hDEAD;
    repeat (2) begin
      @(negedge clk);
      chk("idle_src_ready", bus.src_ready_o, 0);
      chk("idle_src_cnt", src_cnt, mcnt);
      chk("idle_busy", busy, 0);
    end
    bus.src_valid_i = 1'b0;

    // reset in the middle of a chunk
    @(negedge clk);
    bus.mask_valid_i = 1'b1;
    bus.mask_i       = 16'h0007;
    bus.mask_last_i  = 1'b0;
    @(negedge clk);
    bus.mask_valid_i = 1'b0;
    for (int j = 0; j < 2; j++) begin
      bus.src_valid_i = 1'b1;
      bus.src_data_i  = 32'h55 + j;
      @(negedge clk);
    end
    bus.src_valid_i = 1'b0;
    chk("mid_cnt", src_cnt, 2);
    chk("mid_busy", busy, 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("mrst_busy", busy, 0);
    chk("mrst_cnt", src_cnt, 0);
    chk("mrst_out_valid", bus.out_valid_o, 0);
    chk("mrst_mask_ready", bus.mask_ready_o, 1);
    mcnt = 0;
    for (int i = 0; i < 16; i++) mdl[i] = '0;
    run_chunk(16'h0002, 1'b1, 32'h77, 0);

    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

endmodule
